usb_tx_encoder: RTL



---
 rtl/usb_tx_pkg.sv | 27 ++
 rtl/usb_tx_bit_timer.sv | 34 +++
 rtl/usb_tx_encoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg
// Shared definitions for the USB full-speed transmit line encoder:
//   - LINE_J / LINE_K / LINE_SE0 : pad encodings as {D+, D-}
//   - STUFF_LIMIT                : run of ones that forces a stuffed zero
//   - eop_phase_t                : end-of-packet sequencer phases
//   - nrzi_toggle()              : swaps the idle-level J/K pair
package usb_tx_pkg;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int unsigned STUFF_LIMIT = 6;

    typedef enum logic [2:0] {
        EOP_NONE,
        EOP_SE0_1,
        EOP_SE0_2,
        EOP_J,
        EOP_DONE
    } eop_phase_t;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] level);
        return (level == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// usb_tx_bit_timer
// Wrap counter that divides the system clock into USB bit periods.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   enable    : count while high, hold otherwise
//   clear     : synchronous clear back to zero
//   bit_start : high in the cycle where the count is zero while enabled
module usb_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic bit_start
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign bit_start = enable && (count == '0);

endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder
// Line-side stage of the USB full-speed transmitter. Shifts loaded bytes
// out LSB first, one bit per CLKS_PER_BIT clocks, with bit stuffing, NRZI
// encoding and EOP generation.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   enable_timer : FSM active; low aborts and idles the line at J
//   load_enable  : load parallel_in into the shift register
//   parallel_in  : byte to send, LSB first
//   eop_flag     : start the EOP once all pending bits are gone
//   byte_sent    : pulse in the bit-start cycle that consumes bit 7
//   packet_done  : pulse in the bit-start cycle that ends the EOP J bit
//   dplus_out, dminus_out : registered pad drive
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_timer,
    input  logic       load_enable,
    input  logic [7:0] parallel_in,
    input  logic       eop_flag,
    output logic       byte_sent,
    output logic       packet_done,
    output logic       dplus_out,
    output logic       dminus_out
);

    logic       bit_start;

    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bits_left_q, bits_left_d;
    logic [2:0] ones_q, ones_d;
    eop_phase_t phase_q, phase_d;
    logic [1:0] level_q, level_d;
    logic [1:0] line_q, line_d;
    logic       byte_sent_c;
    logic       packet_done_c;

    usb_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable_timer),
        .clear     (!enable_timer),
        .bit_start (bit_start)
    );

    always_ff @(posedge clk) begin
        if (rst || !enable_timer) begin
            shreg_q     <= '0;
            bits_left_q <= '0;
            ones_q      <= '0;
            phase_q     <= EOP_NONE;
            level_q     <= LINE_J;
            line_q      <= LINE_J;
        end else begin
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            ones_q      <= ones_d;
            phase_q     <= phase_d;
            level_q     <= level_d;
            line_q      <= line_d;
        end
    end

    // An EOP already in flight keeps advancing at each bit start; otherwise
    // stuffing beats data, data beats starting the EOP, and anything else
    // simply holds the line. A load always lands after the bit-start update
    // so the bit start consumes the old register contents.
    always_comb begin
        shreg_d       = shreg_q;
        bits_left_d   = bits_left_q;
        ones_d        = ones_q;
        phase_d       = phase_q;
        level_d       = level_q;
        line_d        = line_q;
        byte_sent_c   = 1'b0;
        packet_done_c = 1'b0;

        if (bit_start) begin
            if (phase_q == EOP_SE0_1) begin
                phase_d = EOP_SE0_2;
                line_d  = LINE_SE0;
            end else if (phase_q == EOP_SE0_2) begin
                phase_d = EOP_J;
                level_d = LINE_J;
                line_d  = LINE_J;
            end else if (phase_q == EOP_J) begin
                phase_d       = EOP_DONE;
                packet_done_c = 1'b1;
            end else if (ones_q == 3'(STUFF_LIMIT)) begin
                ones_d  = '0;
                level_d = nrzi_toggle(level_q);
                line_d  = level_d;
            end else if (bits_left_q != '0) begin
                shreg_d     = {1'b0, shreg_q[7:1]};
                bits_left_d = bits_left_q - 4'd1;
                if (shreg_q[0]) begin
                    ones_d = ones_q + 3'd1;
                    line_d = level_q;
                end else begin
                    ones_d  = '0;
                    level_d = nrzi_toggle(level_q);
                    line_d  = level_d;
                end
                byte_sent_c = (bits_left_q == 4'd1);
            end else if (eop_flag && phase_q == EOP_NONE) begin
                phase_d = EOP_SE0_1;
                line_d  = LINE_SE0;
            end
        end

        if (load_enable) begin
            shreg_d     = parallel_in;
            bits_left_d = 4'd8;
        end
    end

    // The bit timer may still read zero during the reset cycle, so the
    // pulses are masked by rst directly.
    assign byte_sent   = byte_sent_c && !rst;
    assign packet_done = packet_done_c && !rst;
    assign dplus_out   = line_q[1];
    assign dminus_out  = line_q[0];

endmodule
